// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped countdown timer.
// CTRL_W grows to cover the PSC field when TIMER_PRESCALE_EN is defined.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_e;

   localparam logic [1:0] CTRL_OFS   = 2'd0;
   localparam logic [1:0] PRESET_OFS = 2'd1;
   localparam logic [1:0] COUNT_OFS  = 2'd2;

   localparam int EN_B     = 0;
   localparam int MODE_LSB = 1;
   localparam int IM_B     = 3;
   localparam int PSC_LSB  = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

`ifdef TIMER_PRESCALE_EN
   localparam int CTRL_W = 8;
`else
   localparam int CTRL_W = 4;
`endif

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler for the timer's CNT state; present only when
// TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       run,
   input  logic [3:0] psc,
   output logic       tick
);

   logic [7:0] pre_q, pre_d, nxt, mask;

   // Tick on the 2^PSC-th CNT edge after LOAD, so N ticks span N*2^PSC edges.
   always_comb begin
      nxt  = pre_q + 8'd1;
      mask = (psc >= 4'd8) ? 8'hFF : 8'((9'd1 << psc) - 9'd1);
      tick = run && ((nxt & mask) == 8'd0);
      pre_d = pre_q;
      if (clr)      pre_d = 8'd0;
      else if (run) pre_d = nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= 8'd0;
      else        pre_q <= pre_d;
   end

endmodule
`endif

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer (CTRL / PRESET / COUNT) with an IRQ toward CP0.
// Define TIMER_PRESCALE_EN to add the CTRL[7:4] PSC prescaler.
module mmio_timer
   import timer_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int IRQ_PULSE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [2:0] PULSE_INIT = 3'(IRQ_PULSE);

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [CNT_W-1:0]    preset_q, preset_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                flag_q, flag_d;
   logic [2:0]          pulse_q, pulse_d;
   logic                tick;
   logic                en;
   logic [1:0]          mode;

   assign en   = ctrl_q[EN_B];
   assign mode = ctrl_q[MODE_LSB +: 2];

`ifdef TIMER_PRESCALE_EN
   timer_prescaler u_psc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == LOAD),
      .run   (state_q == CNT),
      .psc   (ctrl_q[PSC_LSB +: 4]),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;
      pulse_d  = pulse_q;

      // pulse_q counts down the remaining high cycles of an auto-reload pulse
      if (pulse_q != 3'd0) begin
         pulse_d = pulse_q - 3'd1;
         if (pulse_q == 3'd1) flag_d = 1'b0;
      end

      case (state_q)
         IDLE: if (en) state_d = LOAD;
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (tick) begin
               if (count_q > CNT_W'(1)) begin
                  count_d = count_q - CNT_W'(1);
               end else begin
                  count_d = '0;
                  flag_d  = 1'b1;
                  pulse_d = (mode == MODE_RELOAD) ? PULSE_INIT : 3'd0;
                  state_d = INT;
               end
            end
         end
         INT: begin
            if (mode != MODE_RELOAD) ctrl_d[EN_B] = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Software CTRL writes override the FSM's EN clear and drop any pending IRQ.
      if (we) begin
         case (addr)
            CTRL_OFS: begin
               ctrl_d  = din[CTRL_W-1:0];
               flag_d  = 1'b0;
               pulse_d = 3'd0;
            end
            PRESET_OFS: preset_d = din[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         flag_q   <= 1'b0;
         pulse_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
         pulse_q  <= pulse_d;
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         CTRL_OFS:   dout[CTRL_W-1:0] = ctrl_q;
         PRESET_OFS: dout[CNT_W-1:0]  = preset_q;
         COUNT_OFS:  dout[CNT_W-1:0]  = count_q;
         default:    dout = '0;
      endcase
   end

   assign irq = ctrl_q[IM_B] & flag_q;

endmodule
